// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-way request arbiter with IDLE/GRANT/RELEASE FSM, bounded hold time and timeout pulse.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the highest requesting index wins.
module req_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] win;
    logic       grant_now, at_max, rel, keep;
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] last_id_q, last_id_d;
`endif
    // Later loop iterations win, so the last assignment is the highest-priority requester.
    always_comb begin
        win = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 8; k >= 1; k--)
            if (req[3'(last_id_q - 3'(k))]) win = 3'(last_id_q - 3'(k));
`else
        for (int i = 0; i < 8; i++)
            if (req[i]) win = 3'(i);
`endif
    end
    assign grant_now = (state_q != GRANT) && (|req);
    assign at_max    = hold_q == 8'(HOLD_MAX);
    assign rel       = !req[gnt_id_q] || done || at_max;
    assign keep      = (state_q == GRANT) && !rel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_id_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_id_q   <= last_id_d;
`endif
        end
    end
    always_comb begin
        state_d = grant_now ? GRANT : (state_q == GRANT) ? (rel ? RELEASE : GRANT) : IDLE;
        hold_d  = grant_now ? 8'd1 : keep ? hold_q + 8'd1 : 8'd0;
    end
    // Timeout only when the hold limit alone ends the grant.
    always_comb begin
        gnt_d       = grant_now ? 8'd1 << win : keep ? gnt_q : 8'd0;
        gnt_id_d    = grant_now ? win : keep ? gnt_id_q : 3'd0;
        gnt_valid_d = grant_now || keep;
        timeout_d   = (state_q == GRANT) && at_max && req[gnt_id_q] && !done;
`ifdef ARB_ROUND_ROBIN_EN
        last_id_d   = grant_now ? win : last_id_q;
`endif
    end
    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: directed table-driven bench for req_arbiter8 with HOLD_MAX=4.
module tb_req_arbiter8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic       clk, rst, done;
    logic [7:0] req, gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid, timeout;
    int         n_checks = 0;
    int         n_fail = 0;

    req_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
    } vec_t;
    vec_t tv[21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] g, input logic [2:0] id,
                         input logic v, input logic to);
        n_checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== {g, id, v, to}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
                     name, gnt, gnt_id, gnt_valid, timeout, g, id, v, to);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Grant integrity on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) || (gnt_valid ? (gnt !== 8'd1 << gnt_id) : (gnt_id !== 3'd0))) begin
                n_fail++;
                $display("FAIL onehot: gnt=%h id=%0d valid=%b", gnt, gnt_id, gnt_valid);
            end
        end
    end

    initial begin
        logic [7:0] g5;
        logic [2:0] i5;
        g5 = RR ? 8'h04 : 8'h20;
        i5 = RR ? 3'd2 : 3'd5;
        tv[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[1]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tv[2]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tv[3]  = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tv[4]  = '{8'h24, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[5]  = '{8'h24, 1'b0, g5,    i5,   1'b1, 1'b0};
        tv[6]  = '{8'hA4, 1'b0, g5,    i5,   1'b1, 1'b0};
        tv[7]  = '{8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[8]  = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[9]  = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[10] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[11] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[12] = '{8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tv[13] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[14] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[15] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[16] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tv[17] = '{8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[18] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[19] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[20] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};

        rst = 1'b1; req = 8'hFF; done = 1'b1;
        #3;
        check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 21; i++) begin
            req = tv[i].req;
            done = tv[i].done;
            step();
            check($sformatf("vec%0d", i), tv[i].g, tv[i].id, tv[i].v, tv[i].to);
        end

        // Owner 3 drops its request and signals done on the same edge while 6 rises.
        do_reset();
        req = 8'h08;
        step();
        check("own3_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h40; done = 1'b1;
        step();
        check("own3_release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step();
        check("own6_grant", 8'h40, 3'd6, 1'b1, 1'b0);

        // Asynchronous reset mid-grant.
        do_reset();
        req = 8'h80;
        step();
        check("pre_async", 8'h80, 3'd7, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_clear", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step();
        check("post_async", 8'h80, 3'd7, 1'b1, 1'b0);

        // All requesting, done on every grant.
        do_reset();
        req = 8'hFF;
        step();
        check("all_first", 8'h80, 3'd7, 1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            logic [2:0] e;
            e = RR ? 3'((7 - n) & 7) : 3'd7;
            done = 1'b1;
            step();
            check($sformatf("all_gap%0d", n), 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
            step();
            check($sformatf("all_grant%0d", n), 8'd1 << e, e, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
